fb_write_arbiter: RTL

- Shares the single framebuffer write port (word address, 32-bit data, 4-bit byte enable) among N_REQ requesters, e.g. display processor, blitter and clear engine.
- Round-robin grants with burst hold, idle timeout and a registered output stage.
- Sits in the gpu_clk domain between the write-side masters and the framebuffer write port.

---
 rtl/fb_write_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
//------------------------------------------------------------------------------
// fb_write_arbiter
//
// Shares the single framebuffer write port among N_REQ write-side masters
// (display processor, blitter, clear engine, ...) in the gpu_clk domain.
// Grants are round-robin. Each grant costs one IDLE arbitration cycle, after
// which the owner streams beats through a one-cycle registered output stage.
//
// Optional feature macro: FB_WRITE_ARBITER_BURST_EN
//   defined   : a grant lasts until req_last, MAX_BURST beats or TIMEOUT
//               idle cycles, whichever comes first.
//   undefined : every grant carries exactly one beat (or ends on TIMEOUT);
//               req_last and MAX_BURST have no effect and no beat counter
//               is built.
//
// Ports:
//   clk        in   gpu clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   [N_REQ]         per-requester beat valid
//   req_ready  out  [N_REQ]         per-requester beat accept (owner only)
//   req_last   in   [N_REQ]         final beat of the requester's burst
//   req_addr   in   [N_REQ*ADDR_W]  packed word addresses
//   req_data   in   [N_REQ*32]      packed write data
//   req_be     in   [N_REQ*4]       packed byte enables
//   fb_wr_addr out  [ADDR_W]        framebuffer write address
//   fb_wr_data out  [32]            framebuffer write data
//   fb_wr_en   out  [4]             framebuffer byte write enables
//   grant_id   out  [$clog2(N_REQ)] current owner (valid while busy)
//   busy       out                  high while a grant is active
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fb_write_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 15,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*32-1:0]       req_data,
  input  logic [N_REQ*4-1:0]        req_be,
  output logic [ADDR_W-1:0]         fb_wr_addr,
  output logic [31:0]               fb_wr_data,
  output logic [3:0]                fb_wr_en,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   last_winner;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;
  logic              hi_found;
  logic              lo_found;
  logic              take_hi;
  logic              take_lo;
  logic              any_valid;
  logic              accept;
  logic              release_grant;
  logic              owner_valid;
  logic              owner_last;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_data;
  logic [3:0]        sel_be;
  logic [IDLE_W-1:0] idle_cnt;

`ifdef FB_WRITE_ARBITER_BURST_EN
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  logic [BEAT_W-1:0] beat_cnt;
`else
  // req_last and MAX_BURST only matter for multi-beat grants
  logic unused_burst_inputs;
  assign unused_burst_inputs = ^{req_last, (MAX_BURST > 0)};
`endif

  assign any_valid = |req_valid;
  assign busy      = (state == GRANT);

  // Round-robin pick: first valid above last_winner, else first valid at or below it
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = {ID_W{1'b0}};
    lo_idx   = {ID_W{1'b0}};
    take_hi  = 1'b0;
    take_lo  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      take_hi  = req_valid[i] && !hi_found && (ID_W'(i) > last_winner);
      take_lo  = req_valid[i] && !lo_found && (ID_W'(i) <= last_winner);
      hi_idx   = take_hi ? ID_W'(i) : hi_idx;
      lo_idx   = take_lo ? ID_W'(i) : lo_idx;
      hi_found = hi_found | take_hi;
      lo_found = lo_found | take_lo;
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  // AND-OR mux of the owner's request fields
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    sel_addr    = {ADDR_W{1'b0}};
    sel_data    = 32'h0000_0000;
    sel_be      = 4'h0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_valid = owner_valid | ((grant_id == ID_W'(i)) & req_valid[i]);
      owner_last  = owner_last  | ((grant_id == ID_W'(i)) & req_last[i]);
      sel_addr    = sel_addr | ({ADDR_W{grant_id == ID_W'(i)}} & req_addr[i*ADDR_W +: ADDR_W]);
      sel_data    = sel_data | ({32{grant_id == ID_W'(i)}} & req_data[i*32 +: 32]);
      sel_be      = sel_be   | ({4{grant_id == ID_W'(i)}} & req_be[i*4 +: 4]);
    end
  end

  // Ready goes only to the owner, and only while granted
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state == GRANT) && (grant_id == ID_W'(i));
    end
  end

  // Next-state logic: accept detection and release decision
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          next_state = GRANT;
        end else begin
          next_state = IDLE;
        end
      end
      GRANT: begin
        accept = owner_valid;
        if (owner_valid) begin
`ifdef FB_WRITE_ARBITER_BURST_EN
          // beat_cnt holds beats already taken, so MAX_BURST-1 means this is the last allowed
          release_grant = owner_last || (beat_cnt == BEAT_W'(MAX_BURST - 1));
`else
          release_grant = 1'b1;
`endif
        end else begin
          // The count reaches TIMEOUT on this edge
          release_grant = (idle_cnt == IDLE_W'(TIMEOUT - 1));
        end
        next_state = release_grant ? IDLE : GRANT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Owner, round-robin pointer and grant counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id    <= {ID_W{1'b0}};
      last_winner <= ID_W'(N_REQ - 1);
      idle_cnt    <= {IDLE_W{1'b0}};
`ifdef FB_WRITE_ARBITER_BURST_EN
      beat_cnt    <= {BEAT_W{1'b0}};
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= winner;
            idle_cnt <= {IDLE_W{1'b0}};
`ifdef FB_WRITE_ARBITER_BURST_EN
            beat_cnt <= {BEAT_W{1'b0}};
`endif
          end
        end
        GRANT: begin
          if (accept) begin
            idle_cnt <= {IDLE_W{1'b0}};
`ifdef FB_WRITE_ARBITER_BURST_EN
            beat_cnt <= beat_cnt + BEAT_W'(1);
`endif
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
          if (release_grant) begin
            last_winner <= grant_id;
          end
        end
        default: begin
          idle_cnt <= {IDLE_W{1'b0}};
        end
      endcase
    end
  end

  // Registered write stage; enables drop on any cycle without an accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_wr_addr <= {ADDR_W{1'b0}};
      fb_wr_data <= 32'h0000_0000;
      fb_wr_en   <= 4'h0;
    end else if (accept) begin
      fb_wr_addr <= sel_addr;
      fb_wr_data <= sel_data;
      fb_wr_en   <= sel_be;
    end else begin
      fb_wr_en   <= 4'h0;
    end
  end

endmodule
